// File: rtl/print_uart_tx.sv
// print_uart_tx: buffers 32-bit words from the core's print port in a FIFO and
// serializes each one onto an 8N1 UART line. It never back-pressures the core:
// a push that finds the FIFO full (with no pop in the same cycle) is dropped
// and OVERFLOW is set.
// Optional build macro PRINT_HEX_ASCII_EN: when defined, each word is sent as
// 8 uppercase ASCII hex digits (MS nibble first) followed by a line feed. When
// it is undefined, the word is sent as 4 raw bytes, little-endian.
// Ports:
//   CLK        system clock (posedge)
//   RESET      asynchronous, active-high reset
//   PRINT_VAL  word to print; PRINT_EN pushes it
//   PRINT_EN   push strobe, one word per high cycle
//   OVF_CLR    synchronous clear of OVERFLOW
//   TX         registered UART line, idle high
//   BUSY       FIFO non-empty or a frame in progress
//   FIFO_LEVEL words currently buffered
//   OVERFLOW   sticky flag, set when a push is dropped
module print_uart_tx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [31:0]                 PRINT_VAL,
  input  logic                        PRINT_EN,
  input  logic                        OVF_CLR,
  output logic                        TX,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef PRINT_HEX_ASCII_EN
  localparam int BI_W = 4;
  localparam logic [BI_W-1:0] LAST_BYTE = 4'd8;
`else
  localparam int BI_W = 2;
  localparam logic [BI_W-1:0] LAST_BYTE = 2'd3;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  state_t        state;

  assign full  = (FIFO_LEVEL == LW'(FIFO_DEPTH));
  assign empty = (FIFO_LEVEL == '0);
  assign pop   = (state == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push  = PRINT_EN && (!full || pop);
  assign drop  = PRINT_EN && full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= PRINT_VAL;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
      end else if (pop && !push) begin
        FIFO_LEVEL <= FIFO_LEVEL - LW'(1);
      end
      // A new drop takes priority over a clear in the same cycle.
      if (drop) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current byte selection
  // ---------------------------------------------------------------------------
  logic [31:0]     hold;
  logic [BI_W-1:0] byte_idx;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   baud_cnt;
  logic [7:0]      cur_byte;
  logic [2:0]      next_bit;

  assign next_bit = bit_idx + 3'd1;

`ifdef PRINT_HEX_ASCII_EN
  logic [31:0] hex_shift;
  logic [3:0]  nib;

  // Shift the wanted nibble to the top: byte index n selects hold[31-4n -: 4].
  assign hex_shift = hold << {byte_idx[2:0], 2'b00};
  assign nib       = hex_shift[31:28];

  always_comb begin
    cur_byte = 8'h0A;
    if (byte_idx != LAST_BYTE) begin
      if (nib < 4'd10) begin
        cur_byte = 8'h30 + {4'h0, nib};
      end else begin
        cur_byte = 8'h37 + {4'h0, nib};
      end
    end
  end
`else
  assign cur_byte = hold[{byte_idx, 3'b000} +: 8];
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM; TX is registered alongside the state
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      TX       <= 1'b1;
      hold     <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          TX       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            hold     <= mem[rd_ptr];
            byte_idx <= '0;
            state    <= START;
            TX       <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            TX       <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              bit_idx <= next_bit;
              TX      <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              // Next byte of the same word follows with no idle gap.
              byte_idx <= byte_idx + BI_W'(1);
              state    <= START;
              TX       <= 1'b0;
            end else begin
              state <= IDLE;
              TX    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE) || !empty;

endmodule

// File: tb/tb_print_uart_tx.sv
module tb_print_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef PRINT_HEX_ASCII_EN
  localparam int NB = 9;
`else
  localparam int NB = 4;
`endif
  localparam int WORD_CYC = NB * 10 * CPB;

  logic        CLK;
  logic        RESET;
  logic [31:0] PRINT_VAL;
  logic        PRINT_EN;
  logic        OVF_CLR;
  logic        TX;
  logic        BUSY;
  logic [$clog2(DEPTH):0] FIFO_LEVEL;
  logic        OVERFLOW;

  print_uart_tx #(
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PRINT_VAL (PRINT_VAL),
    .PRINT_EN  (PRINT_EN),
    .OVF_CLR   (OVF_CLR),
    .TX        (TX),
    .BUSY      (BUSY),
    .FIFO_LEVEL(FIFO_LEVEL),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  // UART monitor: samples TX mid-bit on the falling clock edge.
  int         rx_q[$];
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge CLK) begin
    if (RESET) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (TX === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= CPB + CPB / 2 && mon_cnt < 9 * CPB &&
          (mon_cnt - CPB - CPB / 2) % CPB == 0) begin
        mon_byte[(mon_cnt - CPB - CPB / 2) / CPB] = TX;
      end
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        // A bad stop bit is recorded as an out-of-range value.
        rx_q.push_back((TX === 1'b1) ? int'(mon_byte) : (32'h100 | int'(mon_byte)));
        mon_act = 1'b0;
      end
    end
  end

  logic [31:0] exp_w[$];

  function automatic int exp_byte(input logic [31:0] w, input int idx);
`ifdef PRINT_HEX_ASCII_EN
    logic [3:0] nib;
    if (idx == 8) return 32'h0A;
    nib = w[31 - 4 * idx -: 4];
    return (nib < 4'd10) ? 32'h30 + int'(nib) : 32'h37 + int'(nib);
`else
    return int'(w[8 * idx +: 8]);
`endif
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int n);
    n = 0;
    while (BUSY !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, BUSY, 0);
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_w.size() * NB);
    for (int w = 0; w < exp_w.size(); w++) begin
      for (int b = 0; b < NB; b++) begin
        int i;
        i = w * NB + b;
        chk(tag, (i < rx_q.size()) ? rx_q[i] : -1, exp_byte(exp_w[w], b));
      end
    end
  endtask

  initial begin
    int n;
    int max_lvl;

    RESET     = 1'b0;
    PRINT_VAL = '0;
    PRINT_EN  = 1'b0;
    OVF_CLR   = 1'b0;

    // ---- reset and idle ----
    #1 RESET = 1'b1;
    #1;
    chk("rst_tx", TX, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_ovf", OVERFLOW, 0);
    repeat (3) tick();
    RESET = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_tx", TX, 1);
      chk("idle_busy", BUSY, 0);
      chk("idle_level", FIFO_LEVEL, 0);
      chk("idle_ovf", OVERFLOW, 0);
    end

    // ---- single word ----
    rx_q.delete();
    exp_w.delete();
    PRINT_VAL = 32'h12345678;
    PRINT_EN  = 1'b1;
    tick();                       // edge k: push
    PRINT_EN = 1'b0;
    chk("single_level_k", FIFO_LEVEL, 1);
    chk("single_tx_k", TX, 1);
    chk("single_busy_k", BUSY, 1);
    tick();                       // edge k+1: pop, start bit
    chk("single_tx_fall", TX, 0);
    chk("single_level_k1", FIFO_LEVEL, 0);
    wait_idle("single", 4 * WORD_CYC, n);
    chk("single_busy_len", n, WORD_CYC);
    exp_w.push_back(32'h12345678);
    chk_rx("single_rx");

    // ---- overflow: six consecutive pushes into a depth-4 FIFO ----
    rx_q.delete();
    exp_w.delete();
    max_lvl = 0;
    for (int i = 1; i <= 6; i++) begin
      PRINT_VAL = i;
      PRINT_EN  = 1'b1;
      tick();
      if (int'(FIFO_LEVEL) > max_lvl) max_lvl = int'(FIFO_LEVEL);
    end
    PRINT_EN = 1'b0;
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_peak_level", max_lvl, DEPTH);
    wait_idle("ovf", 8 * WORD_CYC, n);
    chk("ovf_sticky", OVERFLOW, 1);
    for (int i = 1; i <= 5; i++) exp_w.push_back(i);
    chk_rx("ovf_rx");
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    chk("ovf_clr", OVERFLOW, 0);

    // ---- full FIFO plus simultaneous pop ----
    rx_q.delete();
    exp_w.delete();
    for (int i = 0; i < 5; i++) begin
      PRINT_VAL = 32'hA0000000 + i;
      PRINT_EN  = 1'b1;
      tick();                     // edges e0..e0+4; pop of word 0 at e0+1
      exp_w.push_back(32'hA0000000 + i);
    end
    PRINT_EN = 1'b0;
    chk("full_level", FIFO_LEVEL, DEPTH);
    repeat (WORD_CYC - 3) tick(); // edge e0+1+WORD_CYC: FSM back in IDLE
    chk("full_idle_tx", TX, 1);
    chk("full_idle_level", FIFO_LEVEL, DEPTH);
    PRINT_VAL = 32'hA0000005;
    PRINT_EN  = 1'b1;
    tick();                       // pop and push on the same edge
    PRINT_EN = 1'b0;
    exp_w.push_back(32'hA0000005);
    chk("full_pop_tx", TX, 0);
    chk("full_pop_level", FIFO_LEVEL, DEPTH);
    chk("full_pop_ovf", OVERFLOW, 0);
    wait_idle("full", 8 * WORD_CYC, n);
    chk_rx("full_rx");

    // ---- pointer wrap: 3*DEPTH words, one per word time ----
    rx_q.delete();
    exp_w.delete();
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      PRINT_VAL = 32'h01010101 * i + 32'h00C0FFEE;
      PRINT_EN  = 1'b1;
      tick();
      PRINT_EN = 1'b0;
      exp_w.push_back(32'h01010101 * i + 32'h00C0FFEE);
      wait_idle("wrap", 2 * WORD_CYC, n);
    end
    chk_rx("wrap_rx");
    chk("wrap_ovf", OVERFLOW, 0);

    // ---- reset during DATA bit 3 of byte 1 ----
    PRINT_VAL = 32'h00000000;
    PRINT_EN  = 1'b1;
    tick();                       // e0: push
    PRINT_VAL = 32'h11111111;
    tick();                       // e0+1: pop word 0, push word 1
    PRINT_EN = 1'b0;
    repeat (14 * CPB + 1) tick(); // one cycle into bit 3 of byte 1
    chk("midrst_tx_before", TX, 0);
    chk("midrst_level_before", FIFO_LEVEL, 1);
    RESET = 1'b1;
    #1;
    chk("midrst_tx_async", TX, 1);
    chk("midrst_level", FIFO_LEVEL, 0);
    chk("midrst_busy", BUSY, 0);
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    rx_q.delete();
    exp_w.delete();
    PRINT_VAL = 32'hA5A5A5A5;
    PRINT_EN  = 1'b1;
    tick();
    PRINT_EN = 1'b0;
    exp_w.push_back(32'hA5A5A5A5);
    wait_idle("after_rst", 4 * WORD_CYC, n);
    chk_rx("after_rst_rx");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
